// File: rtl/fire_sched_pkg.sv
// rtl/fire_sched_pkg.sv - shared types and defaults for the fire-module schedulers
package fire_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int DEF_ADDR    = 4;     // weight ROM address width, CH = 2**ADDR
    localparam int DEF_NUM_PIX = 3025;  // 55x55 output pixels
    localparam int DEF_PIX_W   = 12;    // pixel counter width

endpackage

// File: rtl/expand1x1_sched.sv
// rtl/expand1x1_sched.sv - expand 1x1 convolution channel/pixel sequencer
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start / busy / done      one feature map per start pulse
//   in_valid / in_ready      feature word handshake from the squeeze buffer
//   rom_addr                 shared weight ROM address (current channel)
//   mac_en/acc_clr/acc_last  MAC array accumulate controls
//   out_valid / out_ready    one result handshake per pixel
//   pix_idx                  index of the pixel presented on out_valid
module expand1x1_sched
    import fire_sched_pkg::*;
#(
    parameter int ADDR    = DEF_ADDR,
    parameter int NUM_PIX = DEF_NUM_PIX,
    parameter int PIX_W   = DEF_PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ADDR-1:0]  rom_addr,
    output logic             mac_en,
    output logic             acc_clr,
    output logic             acc_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] pix_idx
);

    localparam logic [ADDR-1:0]  CH_LAST  = {ADDR{1'b1}};
    localparam logic [ADDR-1:0]  CH_ONE   = ADDR'(1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIX - 1);
    localparam logic [PIX_W-1:0] PIX_ONE  = PIX_W'(1);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [ADDR-1:0]  r_ch_cnt;
    logic [PIX_W-1:0] r_pix_cnt;
    logic [PIX_W-1:0] r_pix_idx;
    logic             r_out_valid;

    logic w_ch_last;
    logic w_pix_last;
    logic w_in_ready;
    logic w_busy;
    logic w_done;
    logic w_mac_en;
    logic w_acc_last;

    assign w_ch_last  = (r_ch_cnt == CH_LAST);
    assign w_pix_last = (r_pix_cnt == PIX_LAST);
    assign w_mac_en   = in_valid & w_in_ready;
    assign w_acc_last = w_mac_en & w_ch_last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_acc_last && w_pix_last) w_state_nxt = FLUSH;
            FLUSH:   if (r_out_valid && out_ready) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic. The accumulators are snapshotted on acc_last, so the
    // next pixel may stream in while a result is pending; only its final
    // channel is held back, which keeps a second acc_last from overwriting
    // an unaccepted result.
    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b1;
        w_done     = 1'b0;
        case (r_state)
            IDLE:    w_busy = 1'b0;
            RUN:     w_in_ready = !(r_out_valid && !out_ready && w_ch_last);
            FLUSH:   w_in_ready = 1'b0;
            DONE:    w_done = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    // Channel and pixel counters; pix_idx captures the finishing pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch_cnt  <= '0;
            r_pix_cnt <= '0;
            r_pix_idx <= '0;
        end else if (r_state == IDLE && start) begin
            r_ch_cnt  <= '0;
            r_pix_cnt <= '0;
            r_pix_idx <= '0;
        end else if (w_mac_en) begin
            r_ch_cnt <= r_ch_cnt + CH_ONE;
            if (w_ch_last) begin
                r_pix_idx <= r_pix_cnt;
                if (!w_pix_last) begin
                    r_pix_cnt <= r_pix_cnt + PIX_ONE;
                end
            end
        end
    end

    // Result valid: a new acc_last wins over the writer's acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (w_acc_last) begin
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign busy      = w_busy;
    assign done      = w_done;
    assign in_ready  = w_in_ready;
    assign rom_addr  = r_ch_cnt;
    assign mac_en    = w_mac_en;
    assign acc_clr   = w_mac_en & (r_ch_cnt == '0);
    assign acc_last  = w_acc_last;
    assign out_valid = r_out_valid;
    assign pix_idx   = r_pix_idx;

endmodule

// File: tb/tb_expand1x1_sched.sv
// tb/tb_expand1x1_sched.sv - directed self-checking bench for expand1x1_sched
module tb_expand1x1_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Small map instance: 10 pixels
    logic       start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic       busy, done, in_ready, mac_en, acc_clr, acc_last, out_valid;
    logic [3:0] rom_addr;
    logic [3:0] pix_idx;

    // Full 3025-pixel instance
    logic        f_start = 1'b0, f_in_valid = 1'b0, f_out_ready = 1'b0;
    logic        f_busy, f_done, f_in_ready, f_mac_en, f_acc_clr, f_acc_last, f_out_valid;
    logic [3:0]  f_rom_addr;
    logic [11:0] f_pix_idx;

    int checks = 0;
    int errors = 0;

    expand1x1_sched #(.ADDR(4), .NUM_PIX(10), .PIX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .rom_addr(rom_addr),
        .mac_en(mac_en), .acc_clr(acc_clr), .acc_last(acc_last),
        .out_valid(out_valid), .out_ready(out_ready), .pix_idx(pix_idx)
    );

    expand1x1_sched #(.ADDR(4), .NUM_PIX(3025), .PIX_W(12)) dut_full (
        .clk(clk), .rst_n(rst_n), .start(f_start), .busy(f_busy), .done(f_done),
        .in_valid(f_in_valid), .in_ready(f_in_ready), .rom_addr(f_rom_addr),
        .mac_en(f_mac_en), .acc_clr(f_acc_clr), .acc_last(f_acc_last),
        .out_valid(f_out_valid), .out_ready(f_out_ready), .pix_idx(f_pix_idx)
    );

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] outs;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            outs = {busy, done, in_ready, mac_en, acc_clr, acc_last, out_valid,
                    rom_addr == 4'd0 ? 1'b0 : 1'b1, pix_idx == 4'd0 ? 1'b0 : 1'b1,
                    f_busy, f_out_valid};
            checks++;
            if (outs !== 11'd0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d got %b exp 0", i, outs);
            end
        end
    endtask

    task automatic test_single_pixel();
        logic [3:0] ch;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        do_start();
        for (int k = 0; k < 160; k++) begin
            ch = 4'(k % 16);
            checks++;
            if (rom_addr !== ch || mac_en !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL seq_addr k=%0d got addr %0d mac %b busy %b exp addr %0d mac 1 busy 1",
                         k, rom_addr, mac_en, busy, ch);
            end
            checks++;
            if (acc_clr !== (ch == 4'd0) || acc_last !== (ch == 4'd15)) begin
                errors++;
                $display("FAIL seq_clr_last k=%0d got clr %b last %b", k, acc_clr, acc_last);
            end
            checks++;
            if (out_valid !== (k >= 16 && ch == 4'd0)) begin
                errors++;
                $display("FAIL seq_out_valid k=%0d got %b exp %b", k, out_valid, (k >= 16 && ch == 4'd0));
            end
            if (k >= 16 && ch == 4'd0) begin
                checks++;
                if (pix_idx !== 4'(k / 16 - 1)) begin
                    errors++;
                    $display("FAIL seq_pix_idx k=%0d got %0d exp %0d", k, pix_idx, k / 16 - 1);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b1 || pix_idx !== 4'd9 || in_ready !== 1'b0 || mac_en !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL seq_flush got ov %b idx %0d rdy %b mac %b done %b exp 1 9 0 0 0",
                     out_valid, pix_idx, in_ready, mac_en, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_done got done %b busy %b ov %b exp 1 1 0", done, busy, out_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL seq_idle got done %b busy %b exp 0 0", done, busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_bubbles();
        int   acc = 0;
        int   macs = 0;
        int   dones = 0;
        logic exp_ov = 1'b0;
        logic exp_mac;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        do_start();
        for (int cyc = 0; cyc < 340; cyc++) begin
            in_valid = (cyc % 2 == 0);
            #1;
            exp_mac = in_valid && (acc < 160);
            checks++;
            if (mac_en !== exp_mac || rom_addr !== 4'(acc % 16) || out_valid !== exp_ov) begin
                errors++;
                $display("FAIL bubble cyc=%0d got mac %b addr %0d ov %b exp %b %0d %b",
                         cyc, mac_en, rom_addr, out_valid, exp_mac, acc % 16, exp_ov);
            end
            if (exp_ov) begin
                checks++;
                if (pix_idx !== 4'(acc / 16 - 1)) begin
                    errors++;
                    $display("FAIL bubble_pix cyc=%0d got %0d exp %0d", cyc, pix_idx, acc / 16 - 1);
                end
            end
            if (mac_en) macs++;
            if (done) dones++;
            exp_ov = exp_mac && (acc % 16 == 15);
            if (exp_mac) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (macs != 160 || dones != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bubble_totals got mac %0d done %0d busy %b exp 160 1 0", macs, dones, busy);
        end
    endtask

    task automatic test_backpressure();
        int seen = 0;
        logic [3:0] exp_ch;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        do_start();
        repeat (16) @(negedge clk);
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || pix_idx !== 4'd0 || acc_clr !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_overlap got ov %b idx %0d clr %b rdy %b exp 1 0 1 1",
                     out_valid, pix_idx, acc_clr, in_ready);
        end
        for (int j = 0; j < 20; j++) begin
            exp_ch = (j < 15) ? 4'(j) : 4'd15;
            checks++;
            if (rom_addr !== exp_ch || in_ready !== (j < 15) || acc_last !== 1'b0 ||
                out_valid !== 1'b1 || pix_idx !== 4'd0) begin
                errors++;
                $display("FAIL bp_hold j=%0d got addr %0d rdy %b last %b ov %b idx %0d exp %0d %b 0 1 0",
                         j, rom_addr, in_ready, acc_last, out_valid, pix_idx, exp_ch, (j < 15));
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || acc_last !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_resume got rdy %b last %b ov %b exp 1 1 1", in_ready, acc_last, out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || pix_idx !== 4'd1 || rom_addr !== 4'd0) begin
            errors++;
            $display("FAIL bp_next got ov %b idx %0d addr %0d exp 1 1 0", out_valid, pix_idx, rom_addr);
        end
        for (int c = 0; c < 200 && seen == 0; c++) begin
            if (done) seen = 1;
            @(negedge clk);
        end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL bp_done timeout got %0d exp 1", seen);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_abort();
        int dones = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        do_start();
        repeat (7 * 16 + 9) @(negedge clk);
        checks++;
        if (rom_addr !== 4'd9 || pix_idx !== 4'd6 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pos got addr %0d idx %0d busy %b exp 9 6 1", rom_addr, pix_idx, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, in_ready, mac_en, acc_clr, acc_last, out_valid} !== 7'd0 ||
            rom_addr !== 4'd0 || pix_idx !== 4'd0) begin
            errors++;
            $display("FAIL abort_async got busy %b rdy %b mac %b ov %b addr %0d idx %0d exp all 0",
                     busy, in_ready, mac_en, out_valid, rom_addr, pix_idx);
        end
        repeat (2) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (done) dones++;
        checks++;
        if (dones != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done got done %0d busy %b exp 0 0", dones, busy);
        end
        do_start();
        checks++;
        if (rom_addr !== 4'd0 || pix_idx !== 4'd0 || busy !== 1'b1 || acc_clr !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart got addr %0d idx %0d busy %b clr %b exp 0 0 1 1",
                     rom_addr, pix_idx, busy, acc_clr);
        end
        for (int c = 0; c < 300 && busy; c++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_finish timeout busy %b exp 0", busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full_map();
        int macs = 0;
        int hs = 0;
        int dones = 0;
        int exp_pix = 0;
        int cyc = 0;
        @(negedge clk);
        f_start = 1'b1;
        @(negedge clk);
        f_start = 1'b0;
        while (f_busy && cyc < 70000) begin
            f_in_valid  = ($urandom_range(0, 9) != 0);
            f_out_ready = ($urandom_range(0, 9) != 0);
            #1;
            checks++;
            if (f_mac_en !== (f_in_valid & f_in_ready)) begin
                errors++;
                $display("FAIL full_mac_en cyc=%0d got %b exp %b", cyc, f_mac_en, f_in_valid & f_in_ready);
            end
            if (f_mac_en) macs++;
            if (f_done) dones++;
            if (f_out_valid && f_out_ready) begin
                checks++;
                if (f_pix_idx !== 12'(exp_pix)) begin
                    errors++;
                    $display("FAIL full_pix_order got %0d exp %0d", f_pix_idx, exp_pix);
                end
                exp_pix++;
                hs++;
            end
            cyc++;
            @(negedge clk);
        end
        f_in_valid  = 1'b0;
        f_out_ready = 1'b0;
        checks++;
        if (f_busy !== 1'b0) begin
            errors++;
            $display("FAIL full_timeout got busy %b exp 0", f_busy);
        end
        checks++;
        if (hs != 3025 || macs != 48400 || dones != 1) begin
            errors++;
            $display("FAIL full_totals got hs %0d mac %0d done %0d exp 3025 48400 1", hs, macs, dones);
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_bubbles();
        test_backpressure();
        test_abort();
        test_full_map();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
